// File: rtl/bioz_afe_dtbpsdm_therm_dwa_encoder.sv
// Clocked thermometer-to-binary encoder with bubble detection and DWA unit-element rotation.
// Define DTBPSDM_OVL_MON_EN to add the saturating full-scale overload monitor and ovl_flag port.
module bioz_afe_dtbpsdm_therm_dwa_encoder #(
   parameter int B         = 2,
   parameter int OVL_LIMIT = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_en,
   input  logic [(2**B)-2:0]   therm,
   input  logic                mode,
   input  logic                dwa_en,
   output logic [B-1:0]        outp,
   output logic [B-1:0]        outn,
   output logic [(2**B)-2:0]   dac_sel,
   output logic                out_valid,
`ifdef DTBPSDM_OVL_MON_EN
   output logic                ovl_flag,
`endif
   output logic                bubble_err
);

   localparam int M     = (2**B) - 1;
   localparam int PTR_W = (M > 1) ? $clog2(M) : 1;

   if (B < 1 || B > 5 || OVL_LIMIT < 1 || OVL_LIMIT > 255) begin : g_bad_param
      $error("bioz_afe_dtbpsdm_therm_dwa_encoder: B or OVL_LIMIT out of range");
   end

   logic [B-1:0]     k_prio, k_pop, k;
   logic [M:0]       therm_x;
   logic             legal;
   logic [M-1:0]     mask, sel;
   logic [2*M-1:0]   rot_wide;
   logic [B:0]       ptr_sum;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [B-1:0]     outp_q, outn_q;
   logic [M-1:0]     dac_q;
   logic             valid_q, bub_q;

   always_comb begin
      k_prio = '0;
      k_pop  = '0;
      for (int i = 0; i < M; i++) begin
         if (therm[i]) k_prio = B'(i + 1);
         k_pop = k_pop + B'(therm[i]);
      end
   end

   assign k       = mode ? k_pop : k_prio;
   // A legal word is 2^j-1, so adding one carries cleanly past every set bit.
   assign therm_x = {1'b0, therm};
   assign legal   = ((therm_x + 1'b1) & therm_x) == '0;

   always_comb begin
      mask = '0;
      for (int i = 0; i < M; i++) mask[i] = (k > B'(i));
   end

   // Rotation modulo M: shift in a 2M-wide window and fold the overflow back down.
   assign rot_wide = {{M{1'b0}}, mask} << ptr_q;
   assign ptr_sum  = (B+1)'(ptr_q) + (B+1)'(k);

   always_comb begin
      sel   = mask;
      ptr_d = '0;
      if (dwa_en) begin
         sel = rot_wide[M-1:0] | rot_wide[2*M-1:M];
         if (ptr_sum >= (B+1)'(M)) ptr_d = PTR_W'(ptr_sum - (B+1)'(M));
         else                      ptr_d = PTR_W'(ptr_sum);
      end
   end

   // sample_en is a strobe with no back-pressure: every high cycle is captured,
   // and out_valid pulses for exactly the cycle after each capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outp_q  <= '0;
         outn_q  <= '1;
         dac_q   <= '0;
         valid_q <= 1'b0;
         bub_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         valid_q <= sample_en;
         if (sample_en) begin
            outp_q <= k;
            outn_q <= ~k;
            dac_q  <= sel;
            bub_q  <= ~legal;
            ptr_q  <= ptr_d;
         end
      end
   end

   assign outp       = outp_q;
   assign outn       = outn_q;
   assign dac_sel    = dac_q;
   assign out_valid  = valid_q;
   assign bubble_err = bub_q;

`ifdef DTBPSDM_OVL_MON_EN
   logic       full_scale;
   logic [7:0] ovl_cnt_q, ovl_cnt_d;
   logic       ovl_q;

   assign full_scale = (k == '0) || (k == B'(M));

   always_comb begin
      ovl_cnt_d = '0;
      if (full_scale) ovl_cnt_d = (ovl_cnt_q == 8'hFF) ? ovl_cnt_q : ovl_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovl_cnt_q <= '0;
         ovl_q     <= 1'b0;
      end else if (sample_en) begin
         ovl_cnt_q <= ovl_cnt_d;
         ovl_q     <= (ovl_cnt_d >= 8'(OVL_LIMIT));
      end
   end

   assign ovl_flag = ovl_q;
`endif

endmodule

// File: tb/tb_bioz_afe_dtbpsdm_therm_dwa_encoder.sv
// Bench for the thermometer/DWA encoder: hand tables for B=2, hand sequences for B=3,
// then randomized traffic on both instances against a loop-based reference model.
module tb_bioz_afe_dtbpsdm_therm_dwa_encoder;

   localparam int M2 = 3;
   localparam int M3 = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       en2, md2, dw2, vld2, bub2;
   logic [2:0] th2, dac2;
   logic [1:0] outp2, outn2;
   logic       en3, md3, dw3, vld3, bub3;
   logic [6:0] th3, dac3;
   logic [2:0] outp3, outn3;
`ifdef DTBPSDM_OVL_MON_EN
   logic       ovl2, ovl3;
`endif

   bioz_afe_dtbpsdm_therm_dwa_encoder #(.B(2), .OVL_LIMIT(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .sample_en(en2), .therm(th2), .mode(md2), .dwa_en(dw2),
      .outp(outp2), .outn(outn2), .dac_sel(dac2), .out_valid(vld2),
`ifdef DTBPSDM_OVL_MON_EN
      .ovl_flag(ovl2),
`endif
      .bubble_err(bub2));

   bioz_afe_dtbpsdm_therm_dwa_encoder #(.B(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .sample_en(en3), .therm(th3), .mode(md3), .dwa_en(dw3),
      .outp(outp3), .outn(outn3), .dac_sel(dac3), .out_valid(vld3),
`ifdef DTBPSDM_OVL_MON_EN
      .ovl_flag(ovl3),
`endif
      .bubble_err(bub3));

   typedef struct {
      logic       en;
      logic [2:0] th;
      logic       md;
      logic       dw;
      logic [1:0] outp;
      logic [1:0] outn;
      logic [2:0] dac;
      logic       vld;
      logic       bub;
   } vec_t;

   int vectors     = 0;
   int miscompares = 0;
   logic [8:0]  exp_q2[$];
   logic [14:0] exp_q3[$];

   // reference model state per instance
   int p2, k2, d2, c2, p3, k3, d3, c3;
   bit b2, o2, b3, o3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic e2, input logic [2:0] t2, input logic m2i, input logic d2i,
                       input logic e3, input logic [6:0] t3, input logic m3i, input logic d3i);
      @(negedge clk);
      en2 = e2; th2 = t2; md2 = m2i; dw2 = d2i;
      en3 = e3; th3 = t3; md3 = m3i; dw3 = d3i;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en2 = 1'b0; en3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      p2 = 0; k2 = 0; d2 = 0; c2 = 0; b2 = 0; o2 = 0;
      p3 = 0; k3 = 0; d3 = 0; c3 = 0; b3 = 0; o3 = 0;
   endtask

   task automatic model(input int m, input int lim, input bit e, input int th, input bit md,
                        input bit dw, inout int ptr, inout int k_h, inout int dac_h,
                        inout bit bub_h, inout int cnt, inout bit ovl_h);
      int  k;
      bit  legal;
      if (!e) return;
      k = 0;
      for (int i = 0; i < m; i++)
         if (((th >> i) & 1) == 1) k = md ? k + 1 : i + 1;
      legal = 0;
      for (int j = 0; j <= m; j++)
         if (th == (1 << j) - 1) legal = 1;
      dac_h = 0;
      if (dw) begin
         for (int j = 0; j < k; j++) dac_h = dac_h | (1 << ((ptr + j) % m));
         ptr = (ptr + k) % m;
      end else begin
         for (int j = 0; j < k; j++) dac_h = dac_h | (1 << j);
         ptr = 0;
      end
      k_h   = k;
      bub_h = !legal;
      if (k == 0 || k == m) cnt = (cnt < 255) ? cnt + 1 : 255;
      else                  cnt = 0;
      ovl_h = (cnt >= lim);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      vec_t tbl[14];
      logic [8:0]  e2v;
      logic [14:0] e3v;
      logic        re2, re3, rm2, rm3, rd2, rd3;
      int          rt2, rt3;

      tbl[0]  = '{1'b1, 3'b011, 1'b0, 1'b0, 2'd2, 2'd1, 3'b011, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 3'b101, 1'b0, 1'b0, 2'd3, 2'd0, 3'b111, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 3'b101, 1'b1, 1'b0, 2'd2, 2'd1, 3'b011, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd2, 2'd1, 3'b011, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 2'd1, 3'b011, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 2'd1, 3'b101, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 2'd1, 3'b110, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd3, 2'd0, 3'b111, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 2'd3, 3'b000, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 3'b001, 1'b0, 1'b1, 2'd1, 2'd2, 3'b001, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 3'b110, 1'b1, 1'b1, 2'd2, 2'd1, 3'b110, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 3'b110, 1'b0, 1'b1, 2'd3, 2'd0, 3'b111, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 3'b001, 1'b0, 1'b0, 2'd1, 2'd2, 3'b001, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 3'b001, 1'b0, 1'b1, 2'd1, 2'd2, 3'b001, 1'b1, 1'b0};

      rst_n = 1'b0;
      en2 = 0; th2 = '0; md2 = 0; dw2 = 0;
      en3 = 0; th3 = '0; md3 = 0; dw3 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_b2", 32'({vld2, bub2, outp2, outn2, dac2}), 32'(9'b0_0_00_11_000));
      check("reset_b3", 32'({vld3, bub3, outp3, outn3, dac3}), 32'(15'b0_0_000_111_0000000));
`ifdef DTBPSDM_OVL_MON_EN
      check("reset_ovl", 32'({ovl2, ovl3}), 32'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].en, tbl[i].th, tbl[i].md, tbl[i].dw, 1'b0, 7'd0, 1'b0, 1'b0);
         check($sformatf("tbl[%0d]", i), 32'({vld2, bub2, outp2, outn2, dac2}),
               32'({tbl[i].vld, tbl[i].bub, tbl[i].outp, tbl[i].outn, tbl[i].dac}));
      end

      // asynchronous reset in the middle of a rotation
      do_reset();
      step(1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
      check("rot_before_rst", 32'(dac2), 32'(3'b011));
      #2;
      rst_n = 1'b0; en2 = 1'b0;
      #1;
      check("async_rst", 32'({vld2, bub2, outp2, outn2, dac2}), 32'(9'b0_0_00_11_000));
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
      check("after_rst", 32'({vld2, bub2, outp2, outn2, dac2}), 32'(9'b1_0_01_10_001));

      // B=3: repeated k=5 walks ptr 5,3,1,6 with a hold gap
      do_reset();
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0011111, 1'b0, 1'b1);
      check("b3_k5_0", 32'({vld3, bub3, outp3, outn3, dac3}), 32'({2'b10, 3'd5, 3'd2, 7'b0011111}));
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0011111, 1'b0, 1'b1);
      check("b3_k5_1", 32'(dac3), 32'(7'b1100111));
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0011111, 1'b0, 1'b1);
      check("b3_k5_2", 32'(dac3), 32'(7'b1111001));
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0011111, 1'b0, 1'b1);
      check("b3_k5_3", 32'(dac3), 32'(7'b0111110));
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 7'b1111111, 1'b1, 1'b0);
      check("b3_gap", 32'({vld3, bub3, outp3, outn3, dac3}), 32'({2'b00, 3'd5, 3'd2, 7'b0111110}));
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 7'b0011111, 1'b0, 1'b1);
      check("b3_k5_4", 32'({vld3, dac3}), 32'({1'b1, 7'b1001111}));

`ifdef DTBPSDM_OVL_MON_EN
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
         check($sformatf("ovl_run[%0d]", i), 32'(ovl2), (i == 3) ? 32'd1 : 32'd0);
      end
      step(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
      check("ovl_clear", 32'(ovl2), 32'd0);
`endif

      do_reset();
      for (int n = 0; n < 400; n++) begin
         re2 = ($urandom_range(0, 3) != 0);
         re3 = ($urandom_range(0, 3) != 0);
         rt2 = $urandom_range(0, 1) ? (1 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 7);
         rt3 = $urandom_range(0, 1) ? (1 << $urandom_range(0, 7)) - 1 : $urandom_range(0, 127);
         rm2 = 1'($urandom_range(0, 1));
         rm3 = 1'($urandom_range(0, 1));
         rd2 = ($urandom_range(0, 3) != 0);
         rd3 = ($urandom_range(0, 3) != 0);
         step(re2, 3'(rt2), rm2, rd2, re3, 7'(rt3), rm3, rd3);
         model(M2, 4, re2, rt2, rm2, rd2, p2, k2, d2, b2, c2, o2);
         model(M3, 8, re3, rt3, rm3, rd3, p3, k3, d3, b3, c3, o3);
         exp_q2.push_back({re2, b2, 2'(k2), 2'(M2 - k2), 3'(d2)});
         exp_q3.push_back({re3, b3, 3'(k3), 3'(M3 - k3), 7'(d3)});
         e2v = exp_q2.pop_front();
         e3v = exp_q3.pop_front();
         check($sformatf("rnd_b2[%0d]", n), 32'({vld2, bub2, outp2, outn2, dac2}), 32'(e2v));
         check($sformatf("rnd_b3[%0d]", n), 32'({vld3, bub3, outp3, outn3, dac3}), 32'(e3v));
`ifdef DTBPSDM_OVL_MON_EN
         check($sformatf("rnd_ovl[%0d]", n), 32'({ovl2, ovl3}), 32'({o2, o3}));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bioz_afe_dtbpsdm_therm_dwa_encoder.md
Name: bioz_afe_dtbpsdm_therm_dwa_encoder

Overview:
Parametrised, clocked successor to the combinational 4-level quantizer encoder in the DT bandpass sigma-delta modulator.
- Samples the (2^B − 1)-bit comparator thermometer word on a strobe.
- Bubble-checks it and encodes it to complementary binary codes (outp / outn).
- Drives the feedback DAC unit-element select with data-weighted averaging (DWA) rotation.
- Sits between the quantizer comparator bank and the feedback DAC / decimation filter.

Parameters:
- B, 2, quantizer bits. Levels L = 2^B; thermometer width and DAC element count M = L−1. Legal range 1..5.
- PTR_W, derived = clog2(M) (min 1), DWA pointer width. Not overridable.
- OVL_LIMIT, 8, consecutive full-scale samples before ovl_flag asserts (overload-monitor build only). Legal range 1..255.

Ports:
- clk, in, 1, modulator clock.
- rst_n, in, 1, asynchronous active-low reset.
- sample_en, in, 1, comparator-latch-done strobe; therm, mode and dwa_en are captured on clk when this is 1.
- therm, in, M, comparator outputs. Bit i = 1 means input is above threshold i+1.
- mode, in, 1, encode mode. 0 = priority (highest set bit); 1 = ones-count (bubble-tolerant).
- dwa_en, in, 1, 1 = rotate DAC elements; 0 = static thermometer select.
- outp, out, B, binary code k.
- outn, out, B, complement code, L−1−k (bitwise ~outp).
- dac_sel, out, M, DAC unit-element enables.
- out_valid, out, 1, one-cycle pulse when outputs update.
- bubble_err, out, 1, 1 = the sample just encoded was not a legal thermometer word.
- ovl_flag, out, 1, overload indication. Present only with DTBPSDM_OVL_MON_EN.

Behaviour:
- Reset (async assert, sync release): outp=0, outn=all-ones, dac_sel=0, out_valid=0, bubble_err=0, ptr=0, overload counter=0, ovl_flag=0.
- Latency: one clk. sample_en at edge n → outputs and out_valid=1 valid after edge n+1.
- No sample_en: outputs hold their last values; out_valid=0.
- Back-to-back sample_en every cycle is supported; throughput is one sample per clk.
- Code k, mode 0: k = index of highest set bit + 1; k = 0 if therm = 0. For B=2 this equals the legacy 4-level mapping.
- Code k, mode 1: k = popcount(therm).
- bubble_err: 1 when any set bit has a clear bit below it (therm ≠ 2^j − 1 for all j). Registered alongside outp. Encoding proceeds per mode regardless.
- DWA with dwa_en=1:
  - dac_sel sets k consecutive elements starting at ptr, modulo M.
  - Next ptr = (ptr + k) mod M. Wrap is explicit, since M is not a power of 2.
  - k = M: all ones, ptr unchanged.
  - k = 0: all zero, ptr unchanged.
- dwa_en=0: dac_sel = (2^k − 1), elements 0..k−1. ptr is forced to 0 on the same capture.
- Toggling dwa_en from 0 to 1: rotation starts from ptr=0.
- mode and dwa_en affect only the sample captured with them. No mid-sample glitch on outputs.
- Reset mid-operation: all state returns to reset values immediately. The first sample after release starts with ptr=0.
- Invariants checked every out_valid:
  - outp + outn = L−1.
  - popcount(dac_sel) = outp.

Optional Feature:
- Macro: DTBPSDM_OVL_MON_EN.
- Defined:
  - Saturating counter (8 bits) increments on each captured sample with k=0 or k=M; it is cleared by any other k.
  - ovl_flag is registered with the outputs. It is 1 when the counter value after update ≥ OVL_LIMIT, and clears with the first non-full-scale sample.
  - Counter does not wrap; it holds at 255.
- Not defined: counter and ovl_flag port are absent. All other behaviour is identical.

Test Plan:
- B=2, mode 0, dwa_en 0, therm 3'b011 → next cycle outp=2'b10, outn=2'b01, dac_sel=3'b011, out_valid=1, bubble_err=0.
- therm 3'b101: mode 0 → outp=3, bubble_err=1. Mode 1 → outp=2, outn=1, bubble_err=1.
- dwa_en 1, three consecutive samples of therm 3'b011 from reset → dac_sel 3'b011, 3'b101, 3'b110; ptr 2, 1, 0. Then therm 3'b111 → dac_sel 3'b111, ptr stays 0.
- Rotate to ptr=2, assert rst_n=0 mid-stream → outputs to reset values asynchronously. After release, therm 3'b001 → dac_sel 3'b001.
- DTBPSDM_OVL_MON_EN, OVL_LIMIT=4, four samples therm 3'b111 → ovl_flag=1 on the 4th out_valid. Next therm 3'b001 → ovl_flag=0.
- B=3 (M=7), dwa_en 1, repeated k=5 → ptr sequence 5, 3, 1, 6. sample_en gaps → outputs hold and out_valid=0.
